// File: rtl/avmm_uart.sv
// avmm_uart: Avalon-MM serial UART with the JTAG-UART DATA/CONTROL register map.
// Define UART_IRQ_EN to enable the RE/WE interrupt enables, RI/WI status and the irq output.
module avmm_uart #(
  parameter int DATA_W       = 8,
  parameter int TX_DEPTH     = 64,
  parameter int RX_DEPTH     = 64,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        avbus_chipselect,
  input  logic        avbus_address,
  input  logic        avbus_read_n,
  output logic [31:0] avbus_readdata,
  input  logic        avbus_write_n,
  input  logic [31:0] avbus_writedata,
  output logic        avbus_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq
);
  localparam int TW = $clog2(TX_DEPTH);
  localparam int RW = $clog2(RX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  logic req, phase, rd, wr, ctrl_w, rd_pop;
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TW-1:0] tx_wp, tx_rp;
  logic [RW-1:0] rx_wp, rx_rp;
  logic [TW:0] tx_cnt;
  logic [RW:0] rx_cnt;
  logic tx_push, tx_pop, tx_full, rx_push, rx_pop, rx_full, rx_good, rx_bad;
  logic [CW-1:0] tx_clk, rx_clk;
  logic [3:0] tx_bit, rx_bit;
  logic tx_end, rx_end, rx_half;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic rx_s1, rx_s2, rx_d;
  logic rx_ovr, frame_err, tx_ovf, re, we, ri, wi;
  logic [31:0] data_rd, ctrl_rd;
  logic unused;

  // Two-cycle access: phase marks cycle B, where side effects commit.
  assign req = avbus_chipselect & (~avbus_read_n | ~avbus_write_n);
  assign avbus_waitrequest = req & ~phase;
  assign rd = req & phase & ~avbus_read_n;
  assign wr = req & phase & ~avbus_write_n;
  assign ctrl_w = wr & avbus_address;
  assign unused = ^avbus_writedata;

  assign tx_full = tx_cnt == (TW+1)'(TX_DEPTH);
  assign rx_full = rx_cnt == (RW+1)'(RX_DEPTH);
  assign tx_push = wr & ~avbus_address & ~tx_full;
  assign rx_push = rx_good & ~rx_full;
  assign rx_pop = rd & rd_pop;
  assign ri = re & (rx_cnt != '0);
  assign wi = we & (tx_cnt == '0);
  assign data_rd = rx_cnt == '0 ? '0 : {16'(rx_cnt - 1'b1), 1'b1, 15'(rx_mem[rx_rp])};
  assign ctrl_rd = {16'((TW+1)'(TX_DEPTH) - tx_cnt), 3'b0, tx_ovf, frame_err, rx_ovr, wi, ri, 6'b0, we, re};

  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      phase <= 1'b0;
      rd_pop <= 1'b0;
      avbus_readdata <= '0;
      rx_ovr <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf <= 1'b0;
      tx_wp <= '0;
      tx_rp <= '0;
      tx_cnt <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      rx_cnt <= '0;
    end else begin
      phase <= req & ~phase;
      rd_pop <= req & ~phase & ~avbus_read_n & ~avbus_address & (rx_cnt != '0);
      if (req & ~phase & ~avbus_read_n) avbus_readdata <= avbus_address ? ctrl_rd : data_rd;
      rx_ovr <= (rx_ovr & ~(ctrl_w & avbus_writedata[10])) | (rx_good & rx_full);
      frame_err <= (frame_err & ~(ctrl_w & avbus_writedata[11])) | rx_bad;
      tx_ovf <= (tx_ovf & ~(ctrl_w & avbus_writedata[12])) | (wr & ~avbus_address & tx_full);
      tx_wp <= tx_wp + TW'(tx_push);
      tx_rp <= tx_rp + TW'(tx_pop);
      tx_cnt <= tx_cnt + (TW+1)'(tx_push) - (TW+1)'(tx_pop);
      rx_wp <= rx_wp + RW'(rx_push);
      rx_rp <= rx_rp + RW'(rx_pop);
      rx_cnt <= rx_cnt + (RW+1)'(rx_push) - (RW+1)'(rx_pop);
    end

  always_ff @(posedge clk_clk) begin
    if (tx_push) tx_mem[tx_wp] <= avbus_writedata[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end

  assign tx_end = tx_clk == CW'(CLKS_PER_BIT - 1);

  always_comb begin
    tx_next = tx_state;
    tx_pop = 1'b0;
    case (tx_state)
      T_IDLE: if (tx_cnt != '0) begin
        tx_pop = 1'b1;
        tx_next = T_START;
      end
      T_START: if (tx_end) tx_next = T_DATA;
      T_DATA: if (tx_end && tx_bit == 4'(DATA_W - 1)) tx_next = T_STOP;
      T_STOP: if (tx_end && tx_bit == 4'(STOP_BITS - 1)) begin
        tx_pop = tx_cnt != '0;
        tx_next = tx_cnt != '0 ? T_START : T_IDLE;
      end
      default: tx_next = T_IDLE;
    endcase
  end

  // txd is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      tx_state <= T_IDLE;
      tx_clk <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_clk <= (tx_state == T_IDLE || tx_end) ? '0 : tx_clk + 1'b1;
      tx_bit <= (tx_next != tx_state) ? '0 : tx_bit + 4'(tx_end);
      if (tx_pop) tx_sh <= tx_mem[tx_rp];
      else if (tx_state == T_DATA && tx_end) tx_sh <= tx_sh >> 1;
      uart_txd <= tx_state == T_START ? 1'b0 : tx_state == T_DATA ? tx_sh[0] : 1'b1;
    end

  assign rx_end = rx_clk == CW'(CLKS_PER_BIT - 1);
  assign rx_half = rx_clk == CW'(CLKS_PER_BIT / 2);
  assign rx_good = rx_state == R_STOP && rx_end && rx_s2;
  assign rx_bad = rx_state == R_STOP && rx_end && !rx_s2;

  // R_WAIT holds off after a framing error until the line idles high again.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE: if (rx_d && !rx_s2) rx_next = R_START;
      R_START: if (rx_half) rx_next = rx_s2 ? R_IDLE : R_DATA;
      R_DATA: if (rx_end && rx_bit == 4'(DATA_W - 1)) rx_next = R_STOP;
      R_STOP: if (rx_end) rx_next = rx_s2 ? R_IDLE : R_WAIT;
      R_WAIT: if (rx_s2) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      rx_state <= R_IDLE;
      rx_clk <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_s1 <= uart_rxd;
      rx_s2 <= rx_s1;
      rx_d <= rx_s2;
      rx_state <= rx_next;
      rx_clk <= (rx_state == R_IDLE || rx_next != rx_state || rx_end) ? '0 : rx_clk + 1'b1;
      rx_bit <= (rx_next != rx_state) ? '0 : rx_bit + 4'(rx_end);
      if (rx_state == R_DATA && rx_end) rx_sh <= {rx_s2, rx_sh[DATA_W-1:1]};
    end

`ifdef UART_IRQ_EN
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      re <= 1'b0;
      we <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ctrl_w) begin
        re <= avbus_writedata[0];
        we <= avbus_writedata[1];
      end
      irq <= ri | wi;
    end
`else
  assign re = 1'b0;
  assign we = 1'b0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_avmm_uart.sv
// tb_avmm_uart: randomized scoreboard bench for avmm_uart (8-bit chars, 64-deep FIFOs, 4 clocks/bit).
`timescale 1ns/1ps
module tb_avmm_uart;
  localparam int CPB = 4;
  logic clk_clk = 1'b0, reset_reset = 1'b1;
  logic avbus_chipselect = 1'b0, avbus_address = 1'b0, avbus_read_n = 1'b1, avbus_write_n = 1'b1;
  logic [31:0] avbus_writedata = '0, avbus_readdata;
  logic avbus_waitrequest, uart_rxd = 1'b1, uart_txd, irq;
  int checks = 0, errors = 0, tx_frames = 0;
  logic [31:0] exp_rd_q[$], mask_rd_q[$];
  logic [7:0] exp_tx[$], mrx[$];
  bit m_ovr, m_fe, m_tovf, m_re, m_we;

  always #5 clk_clk = ~clk_clk;

  avmm_uart #(.DATA_W(8), .TX_DEPTH(64), .RX_DEPTH(64), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .avbus_chipselect(avbus_chipselect),
    .avbus_address(avbus_address), .avbus_read_n(avbus_read_n), .avbus_readdata(avbus_readdata),
    .avbus_write_n(avbus_write_n), .avbus_writedata(avbus_writedata),
    .avbus_waitrequest(avbus_waitrequest), .uart_rxd(uart_rxd), .uart_txd(uart_txd), .irq(irq));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model of the register map, derived from queue contents and flag bits.
  function automatic logic [31:0] ctrl_exp();
`ifdef UART_IRQ_EN
    return {16'd64, 3'b0, m_tovf, m_fe, m_ovr, m_we, m_re && mrx.size() != 0, 6'b0, m_we, m_re};
`else
    return {16'd64, 3'b0, m_tovf, m_fe, m_ovr, 10'b0};
`endif
  endfunction

  function automatic logic [31:0] data_exp();
    logic [7:0] ch;
    if (mrx.size() == 0) return 32'h0;
    ch = mrx.pop_front();
    return {16'(mrx.size()), 1'b1, 7'b0, ch};
  endfunction

  task automatic bus(input bit is_rd, input bit addr, input logic [31:0] wd);
    int n;
    @(posedge clk_clk); #1;
    avbus_chipselect = 1'b1; avbus_address = addr; avbus_read_n = !is_rd; avbus_write_n = is_rd;
    avbus_writedata = wd;
    n = 0;
    do begin @(negedge clk_clk); n++; end while (avbus_waitrequest && n < 8);
    check("bus_wait_cycles", n, 2);
    @(posedge clk_clk); #1;
    avbus_chipselect = 1'b0; avbus_read_n = 1'b1; avbus_write_n = 1'b1;
  endtask

  task automatic rd(input bit addr, input logic [31:0] mask);
    exp_rd_q.push_back(addr ? ctrl_exp() : data_exp());
    mask_rd_q.push_back(mask);
    bus(1'b1, addr, 32'h0);
  endtask

  task automatic wr(input bit addr, input logic [31:0] wd);
    if (addr) begin
      if (wd[10]) m_ovr = 0;
      if (wd[11]) m_fe = 0;
      if (wd[12]) m_tovf = 0;
`ifdef UART_IRQ_EN
      m_re = wd[0]; m_we = wd[1];
`endif
    end else exp_tx.push_back(wd[7:0]);
    bus(1'b0, addr, wd);
  endtask

  task automatic rx_frame(input logic [7:0] ch, input bit good);
    logic [9:0] f;
    f = {good, ch, 1'b0};
    @(posedge clk_clk); #1;
    for (int b = 0; b < 10; b++) begin
      uart_rxd = f[b];
      repeat (CPB) @(posedge clk_clk);
      #1;
    end
    if (good) begin
      if (mrx.size() < 64) mrx.push_back(ch); else m_ovr = 1;
    end else begin
      repeat (CPB) @(posedge clk_clk);
      #1; uart_rxd = 1'b1;
      repeat (2 * CPB) @(posedge clk_clk);
      #1; m_fe = 1;
    end
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while (exp_tx.size() != 0 && n < 5000) begin @(posedge clk_clk); n++; end
    check("tx_drain", exp_tx.size(), 0);
    repeat (12 * CPB) @(posedge clk_clk);
  endtask

  // Read completion monitor: compares readdata in cycle B against the scoreboard.
  always @(negedge clk_clk)
    if (avbus_chipselect && !avbus_read_n && !avbus_waitrequest) begin
      if (exp_rd_q.size() == 0) check("rd_unexpected", avbus_readdata, 32'hxxxxxxxx);
      else begin
        logic [31:0] e, m;
        e = exp_rd_q.pop_front();
        m = mask_rd_q.pop_front();
        check("rd_data", avbus_readdata & m, e & m);
      end
    end

  // Serial TX monitor: every cycle of each frame must match the expected bit.
  initial begin : txmon
    logic [7:0] ch, act;
    logic [9:0] pat;
    bit bad, ab;
    forever begin
      @(negedge clk_clk);
      if (!reset_reset && !uart_txd) begin
        ch = 8'h00;
        if (exp_tx.size() == 0) check("tx_unexpected", 32'(uart_txd), 32'h1);
        else ch = exp_tx.pop_front();
        pat = {1'b1, ch, 1'b0};
        bad = 0; ab = 0; act = '0;
        for (int b = 0; b < 10; b++)
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk_clk);
            if (reset_reset) ab = 1;
            if (uart_txd !== pat[b]) bad = 1;
            if (b >= 1 && b <= 8 && c == CPB / 2) act[b-1] = uart_txd;
          end
        if (!ab) begin
          tx_frames++;
          checks++;
          if (bad || act !== ch) begin
            errors++;
            $display("FAIL tx_frame: got %h (bit timing %s) expected %h", act, bad ? "bad" : "ok", ch);
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, k, f0;
    repeat (3) @(posedge clk_clk);
    #1;
    check("reset_txd", 32'(uart_txd), 1);
    check("reset_irq", 32'(irq), 0);
    check("reset_waitrequest", 32'(avbus_waitrequest), 0);
    check("reset_readdata", avbus_readdata, 0);
    reset_reset = 1'b0;
    rd(1, '1);

    // Directed TX: 0x55, start bit two edges after the completing edge.
    wr(0, 32'h55);
    n = 0;
    while (uart_txd && n < 20) begin @(posedge clk_clk); #1; n++; end
    check("tx_latency", n, 2);
    wait_tx_drain();
    k = $urandom_range(5, 12);
    for (int i = 0; i < k; i++) wr(0, $urandom);
    wait_tx_drain();
    rd(1, '1);

    // Directed and random RX.
    rx_frame(8'hA3, 1);
    repeat (6) @(posedge clk_clk);
    rd(0, '1);
    rd(0, '1);
    k = $urandom_range(3, 8);
    for (int i = 0; i < k; i++) rx_frame(8'($urandom), 1);
    repeat (6) @(posedge clk_clk);
    for (int i = 0; i <= k; i++) rd(0, '1);

    // RX overrun: 65 characters into a 64-deep FIFO.
    for (int i = 0; i < 65; i++) rx_frame(8'($urandom), 1);
    repeat (6) @(posedge clk_clk);
    rd(1, '1);
    rd(0, '1);
    wr(1, 32'h400);
    rd(1, '1);
    for (int i = 0; i < 64; i++) rd(0, '1);

    // Framing error, then a one-cycle glitch that must be ignored.
    rx_frame(8'($urandom), 0);
    repeat (6) @(posedge clk_clk);
    rd(1, '1);
    rd(0, '1);
    @(posedge clk_clk); #1; uart_rxd = 1'b0;
    @(posedge clk_clk); #1; uart_rxd = 1'b1;
    repeat (20) @(posedge clk_clk);
    rd(1, '1);
    rd(0, '1);
    wr(1, 32'h800);
    rd(1, '1);

    // TX overflow: back-to-back writes outrun the serial drain.
    f0 = tx_frames;
    for (int i = 0; i < 80; i++) wr(0, 32'h5A);
    m_tovf = 1;
    rd(1, 32'h0000FFFF);
    n = 0; k = 0;
    while (k < 60 && n < 5000) begin
      @(negedge clk_clk);
      k = uart_txd ? k + 1 : 0;
      n++;
    end
    check("tx_ovf_idle", 32'(k >= 60), 1);
    check("tx_ovf_frames_in_range", 32'(tx_frames - f0 >= 65 && tx_frames - f0 <= 72), 1);
    exp_tx.delete();
    wr(1, 32'h1000);
    exp_tx.delete();
    rd(1, '1);

`ifdef UART_IRQ_EN
    wr(1, 32'h1);
    rd(1, '1);
    rx_frame(8'($urandom), 1);
    repeat (6) @(posedge clk_clk);
    #1;
    check("irq_rx_set", 32'(irq), 1);
    rd(1, '1);
    rd(0, '1);
    check("irq_hold_after_pop", 32'(irq), 1);
    @(posedge clk_clk); #1;
    check("irq_clear_after_pop", 32'(irq), 0);
    wr(1, 32'h2);
    @(posedge clk_clk); #1;
    check("irq_tx_empty", 32'(irq), 1);
    wr(1, 32'h0);
    @(posedge clk_clk); #1;
    check("irq_disabled", 32'(irq), 0);
`else
    wr(1, 32'h3);
    rd(1, '1);
    rx_frame(8'($urandom), 1);
    repeat (6) @(posedge clk_clk);
    #1;
    check("irq_tied_low", 32'(irq), 0);
    rd(1, '1);
    rd(0, '1);
`endif

    // Reset mid-frame: txd must return high without a clock edge.
    wr(0, 32'h00);
    n = 0;
    while (uart_txd && n < 20) begin @(posedge clk_clk); #1; n++; end
    repeat (2 * CPB) @(posedge clk_clk);
    @(negedge clk_clk);
    check("txd_low_before_reset", 32'(uart_txd), 0);
    reset_reset = 1'b1;
    #1;
    check("txd_async_reset", 32'(uart_txd), 1);
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset = 1'b0;
    mrx.delete(); exp_tx.delete();
    m_ovr = 0; m_fe = 0; m_tovf = 0; m_re = 0; m_we = 0;
    rd(1, '1);
    repeat (60) @(posedge clk_clk);
    check("rd_queue_empty", exp_rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/avmm_uart.md
# avmm_uart

Parametrised Avalon-MM serial UART for the USB system's debug path, replacing the JTAG UART where a physical pin pair is needed. It exposes the JTAG-UART-compatible DATA/CONTROL register map on the avbus slave so existing console drivers run unchanged. It adds:
- real TX/RX serial lines
- configurable character width, FIFO depths, bit rate and stop bits
- sticky error flags

## Interface
Parameters:
- DATA_W, 8: character width, 5..9.
- TX_DEPTH, 64: TX FIFO entries, power of 2, 2..32768.
- RX_DEPTH, 64: RX FIFO entries, power of 2, 2..32768.
- CLKS_PER_BIT, 434: clk_clk cycles per serial bit, ≥4.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk_clk  in  1  single clock; everything is synchronous to it.
- reset_reset  in  1  asynchronous, active-high reset.
- avbus_chipselect  in  1  slave select.
- avbus_address  in  1  0 = DATA, 1 = CONTROL.
- avbus_read_n  in  1  active-low read strobe.
- avbus_readdata  out  32  read data.
- avbus_write_n  in  1  active-low write strobe.
- avbus_writedata  in  32  write data.
- avbus_waitrequest  out  1  stall.
- uart_rxd  in  1  serial input, asynchronous, idle high.
- uart_txd  out  1  serial output, idle high.
- irq  out  1  level interrupt.

## Operation
Register map:
- DATA read:
  - [DATA_W-1:0] is the head character.
  - [15] RVALID.
  - [31:16] RAVAIL = RX count after this read.
  - A read pops the RX FIFO only if RVALID=1.
  - When RVALID=0, data bits read 0.
- DATA write:
  - [DATA_W-1:0] is pushed to the TX FIFO.
  - If the TX FIFO is full, the character is dropped and TX_OVF is set.
- CONTROL:
  - [0] RE and [1] WE are R/W interrupt enables.
  - [8] RI = RE & RX non-empty (read-only).
  - [9] WI = WE & TX empty (read-only).
  - [10] RX_OVR, [11] FRAME_ERR and [12] TX_OVF are sticky; write 1 to clear.
  - [31:16] WSPACE = TX_DEPTH − TX count.
  - Unused bits read 0.

TX FSM: IDLE → START → DATA → STOP → IDLE.
- Leaves IDLE when the TX FIFO is non-empty, popping one entry.
- Each state lasts CLKS_PER_BIT cycles; DATA lasts DATA_W bits, LSB first; STOP lasts STOP_BITS bits at 1.
- At the end of STOP, if the FIFO is non-empty the next START follows with no idle gap.

RX FSM: IDLE → START → DATA → STOP.
- uart_rxd passes through a 2-flop synchroniser.
- A synchronised 1→0 edge in IDLE enters START.
- At CLKS_PER_BIT/2 (integer division) the line is rechecked. If it is 1, return to IDLE (glitch, no flag).
- Data bits are then sampled every CLKS_PER_BIT, LSB first.
- The first stop bit is sampled. If it is 0: set FRAME_ERR, discard the character, wait for the line to return to 1, then go IDLE.
- A good character with the RX FIFO full: discard it and set RX_OVR.
- The second stop bit is not checked on RX.

Simultaneous events:
- A bus pop and an RX push in the same cycle are both honoured; the count is unchanged.
- The same applies to a TX push and pop.
- A write-1-clear and a set of the same sticky flag in the same cycle: the set wins.

FIFO counts are log2(DEPTH)+1 bits, zero-extended into 16-bit fields. Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - uart_txd = 1
  - avbus_readdata = 0
  - avbus_waitrequest = 0
  - irq = 0
  - FIFOs empty, RE/WE/flags 0, both FSMs IDLE.
- Reset mid-frame aborts immediately; txd returns to 1 asynchronously.
- Bus access (chipselect & (~read_n | ~write_n)) takes exactly 2 cycles:
  - Cycle A: waitrequest = 1 (combinational from the request).
  - Cycle B: waitrequest = 0 and readdata is valid.
  - Side effects (pop, push, clear) commit at the edge ending cycle B.
  - waitrequest is 0 whenever there is no request.
- readdata holds its last value outside read completions.
- TX latency: on a write into an empty FIFO with TX idle, txd falls on the 2nd rising edge after the completing edge.
- Frame length is (1 + DATA_W + STOP_BITS)·CLKS_PER_BIT cycles.
- RX push occurs at the first-stop-bit sample point + 1 cycle.
- irq is registered: it changes 1 cycle after RI|WI changes.

## Configuration
- UART_IRQ_EN defined:
  - RE/WE are writable.
  - RI/WI are computed as specified.
  - irq = RI | WI, registered.
- UART_IRQ_EN undefined:
  - RE, WE, RI and WI read 0 and writes to them are ignored.
  - irq is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then read CONTROL → 0x00400000 (WSPACE = 64); uart_txd = 1; irq = 0.
- Write DATA 0x55 with CLKS_PER_BIT = 4, DATA_W = 8 → txd bits 0,1,0,1,0,1,0,1,0,1 at 4-cycle spacing. Start bit begins 2 cycles after the write completes.
- Inject 0xA3 on rxd, then read DATA twice:
  - First read → 0x000080A3 (RVALID = 1, RAVAIL = 0).
  - Second read → 0x00000000.
- Inject 65 characters with RX_DEPTH = 64 → RX_OVR = 1, RAVAIL reads 63 on the first pop. Write CONTROL 0x400 → RX_OVR = 0.
- Send a frame with stop bit 0 → FRAME_ERR = 1, nothing pushed. A 1-cycle low glitch on rxd pushes nothing and sets no flag.
- With UART_IRQ_EN: write CONTROL 0x1, then inject a character → irq = 1. Pop the character → irq = 0 one cycle after the read completes.
